// File: rtl/mu0_pkg.sv
// Shared types for the MU0 control unit: opcodes, sequencer states,
// ALU function codes and the decoded EXECUTE control word.
package mu0_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_STA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_JMP = 4'h4,
    OP_JGE = 4'h5,
    OP_JNE = 4'h6,
    OP_STP = 4'h7
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ALU_Y   = 2'b00,
    ALU_ADD = 2'b01,
    ALU_INC = 2'b10,
    ALU_SUB = 2'b11
  } alu_fn_t;

  typedef struct packed {
    logic    x_sel;
    logic    y_sel;
    logic    addr_sel;
    alu_fn_t m;
    logic    pc_en;
    logic    acc_en;
    logic    rd;
    logic    wr;
    logic    mem_op;
    logic    stop;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mu0_if.sv
// Control/datapath boundary of MU0: the datapath supplies opcode, flags and
// memory ready; the control unit drives enables, selects and strobes.
interface mu0_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       Opcode;
  logic             N;
  logic             Z;
  logic             Mem_Ready;
  logic             X_sel;
  logic             Y_sel;
  logic             Addr_sel;
  logic [1:0]       M;
  logic             PC_En;
  logic             IR_En;
  logic             Acc_En;
  logic             Rd;
  logic             Wr;
  logic             Halted;
  logic [CNT_W-1:0] Instr_Count;

  modport master (
    input  Opcode, N, Z, Mem_Ready,
    output X_sel, Y_sel, Addr_sel, M, PC_En, IR_En, Acc_En, Rd, Wr,
           Halted, Instr_Count
  );

  modport slave (
    output Opcode, N, Z, Mem_Ready,
    input  X_sel, Y_sel, Addr_sel, M, PC_En, IR_En, Acc_En, Rd, Wr,
           Halted, Instr_Count
  );
endinterface

// File: rtl/mu0_decoder.sv
// Combinational instruction decoder: opcode and flags to the control word
// used during EXECUTE. Opcodes 8-F decode as NOP.
module mu0_decoder
  import mu0_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       n_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (opcode_t'(opcode_i))
      OP_LDA: begin
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.rd       = 1'b1;
        ctrl_o.acc_en   = 1'b1;
        ctrl_o.mem_op   = 1'b1;
        ctrl_o.m        = ALU_Y;
      end
      OP_STA: begin
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.wr       = 1'b1;
        ctrl_o.mem_op   = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.rd       = 1'b1;
        ctrl_o.acc_en   = 1'b1;
        ctrl_o.mem_op   = 1'b1;
        ctrl_o.m        = (opcode_i == OP_ADD) ? ALU_ADD : ALU_SUB;
      end
      OP_JMP: begin
        ctrl_o.y_sel = 1'b1;
        ctrl_o.pc_en = 1'b1;
      end
      OP_JGE: begin
        ctrl_o.y_sel = 1'b1;
        ctrl_o.pc_en = ~n_i;
      end
      OP_JNE: begin
        ctrl_o.y_sel = 1'b1;
        ctrl_o.pc_en = ~z_i;
      end
      OP_STP:  ctrl_o.stop = 1'b1;
      default: ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer with memory-ready stalls, a HALT state and a
// wrapping retired-instruction counter.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic  Clk,
  input  logic  Reset,
  mu0_if.master bus
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ex;
  logic             ex_done;

  mu0_decoder u_decoder (
    .opcode_i (bus.Opcode),
    .n_i      (bus.N),
    .z_i      (bus.Z),
    .ctrl_o   (ex)
  );

  // Memory ops retire only once memory answers; everything else takes one cycle.
  assign ex_done = (state_q == EXECUTE) && (!ex.mem_op || bus.Mem_Ready);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        FETCH:   if (bus.Mem_Ready) state_q <= EXECUTE;
        EXECUTE: if (ex_done)       state_q <= ex.stop ? HALT : FETCH;
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
      if (ex_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.X_sel    = 1'b0;
    bus.Y_sel    = 1'b0;
    bus.Addr_sel = 1'b0;
    bus.M        = ALU_Y;
    bus.PC_En    = 1'b0;
    bus.IR_En    = 1'b0;
    bus.Acc_En   = 1'b0;
    bus.Rd       = 1'b0;
    bus.Wr       = 1'b0;
    case (state_q)
      FETCH: begin
        bus.Addr_sel = 1'b0;
        bus.Rd       = 1'b1;
        bus.X_sel    = 1'b1;
        bus.M        = ALU_INC;
        bus.IR_En    = bus.Mem_Ready;
        bus.PC_En    = bus.Mem_Ready;
      end
      EXECUTE: begin
        bus.X_sel    = ex.x_sel;
        bus.Y_sel    = ex.y_sel;
        bus.Addr_sel = ex.addr_sel;
        bus.M        = ex.m;
        bus.PC_En    = ex.pc_en;
        bus.Acc_En   = ex.acc_en & bus.Mem_Ready;
        bus.Rd       = ex.rd;
        bus.Wr       = ex.wr;
      end
      default: ;
    endcase
    // Reset abandons any in-flight access immediately, before the state settles.
    if (Reset) begin
      bus.PC_En  = 1'b0;
      bus.IR_En  = 1'b0;
      bus.Acc_En = 1'b0;
      bus.Rd     = 1'b0;
      bus.Wr     = 1'b0;
    end
  end

  assign bus.Halted      = (state_q == HALT);
  assign bus.Instr_Count = cnt_q;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control; counter narrowed to 8 bits so the wrap
// scenario stays short.
module tb_mu0_control;

  localparam int unsigned CW = 8;

  logic Clk = 1'b0;
  logic Reset;
  int   vec  = 0;
  int   errs = 0;

  mu0_if #(.CNT_W(CW)) bus ();

  mu0_control #(.CNT_W(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // {PC_En, IR_En, Acc_En, Rd, Wr}
  logic [4:0] en;
  assign en = {bus.PC_En, bus.IR_En, bus.Acc_En, bus.Rd, bus.Wr};

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    bus.Mem_Ready = 1'b0;
    bus.Opcode = 4'h0;
    bus.N = 1'b0;
    bus.Z = 1'b0;
    #2;
    vec++; if (en !== 5'b00000) begin errs++; $display("FAIL rst_en got %b exp %b", en, 5'b00000); end
    vec++; if (bus.Halted !== 1'b0) begin errs++; $display("FAIL rst_halted got %b exp 0", bus.Halted); end
    vec++; if (bus.Instr_Count !== 8'd0) begin errs++; $display("FAIL rst_count got %0d exp 0", bus.Instr_Count); end
    tick;
    #2 Reset = 1'b0;
    #1;
    vec++; if (en !== 5'b00010) begin errs++; $display("FAIL fetch_stall_en got %b exp %b", en, 5'b00010); end
    vec++; if ({bus.Addr_sel, bus.X_sel, bus.M} !== 4'b0110) begin errs++; $display("FAIL fetch_sel got %b exp 0110", {bus.Addr_sel, bus.X_sel, bus.M}); end
    tick;
    vec++; if (en !== 5'b00010) begin errs++; $display("FAIL fetch_hold_en got %b exp %b", en, 5'b00010); end
    Reset = 1'b1;
    #1;
    vec++; if (en !== 5'b00000) begin errs++; $display("FAIL rst_mid_fetch got %b exp %b", en, 5'b00000); end
    Reset = 1'b0;
    #1;
    vec++; if (en !== 5'b00010) begin errs++; $display("FAIL post_rst_fetch got %b exp %b", en, 5'b00010); end
    vec++; if (bus.Instr_Count !== 8'd0) begin errs++; $display("FAIL post_rst_count got %0d exp 0", bus.Instr_Count); end
  endtask

  task automatic test_alu_ops;
    bus.Opcode = 4'h0;
    bus.Mem_Ready = 1'b1;
    #1;
    vec++; if (en !== 5'b11010) begin errs++; $display("FAIL lda_fetch_en got %b exp %b", en, 5'b11010); end
    vec++; if (bus.M !== 2'b10) begin errs++; $display("FAIL lda_fetch_m got %b exp 10", bus.M); end
    tick;
    vec++; if (en !== 5'b00110) begin errs++; $display("FAIL lda_exec_en got %b exp %b", en, 5'b00110); end
    vec++; if ({bus.Addr_sel, bus.Y_sel, bus.M} !== 4'b1000) begin errs++; $display("FAIL lda_exec_sel got %b exp 1000", {bus.Addr_sel, bus.Y_sel, bus.M}); end
    tick;
    vec++; if (bus.Instr_Count !== 8'd1) begin errs++; $display("FAIL lda_count got %0d exp 1", bus.Instr_Count); end
    vec++; if (en !== 5'b11010) begin errs++; $display("FAIL lda_back_fetch got %b exp %b", en, 5'b11010); end
    bus.Opcode = 4'h2;
    tick;
    vec++; if ({bus.X_sel, bus.M, en} !== 8'b0_01_00110) begin errs++; $display("FAIL add_exec got %b exp %b", {bus.X_sel, bus.M, en}, 8'b0_01_00110); end
    tick;
    bus.Opcode = 4'h3;
    tick;
    vec++; if ({bus.X_sel, bus.M, en} !== 8'b0_11_00110) begin errs++; $display("FAIL sub_exec got %b exp %b", {bus.X_sel, bus.M, en}, 8'b0_11_00110); end
    tick;
    vec++; if (bus.Instr_Count !== 8'd3) begin errs++; $display("FAIL sub_count got %0d exp 3", bus.Instr_Count); end
  endtask

  task automatic test_jumps;
    bus.Opcode = 4'h5;
    bus.N = 1'b1;
    tick;
    vec++; if (en !== 5'b00000) begin errs++; $display("FAIL jge_n1_en got %b exp %b", en, 5'b00000); end
    bus.N = 1'b0;
    #1;
    vec++; if (en !== 5'b10000) begin errs++; $display("FAIL jge_n0_en got %b exp %b", en, 5'b10000); end
    vec++; if ({bus.Y_sel, bus.M} !== 3'b100) begin errs++; $display("FAIL jge_sel got %b exp 100", {bus.Y_sel, bus.M}); end
    tick;
    bus.Opcode = 4'h6;
    bus.Z = 1'b1;
    tick;
    vec++; if (en !== 5'b00000) begin errs++; $display("FAIL jne_z1_en got %b exp %b", en, 5'b00000); end
    bus.Z = 1'b0;
    #1;
    vec++; if (en !== 5'b10000) begin errs++; $display("FAIL jne_z0_en got %b exp %b", en, 5'b10000); end
    tick;
    bus.Opcode = 4'h4;
    tick;
    bus.Mem_Ready = 1'b0;
    #1;
    vec++; if (en !== 5'b10000) begin errs++; $display("FAIL jmp_en got %b exp %b", en, 5'b10000); end
    tick;
    vec++; if (bus.Instr_Count !== 8'd6) begin errs++; $display("FAIL jmp_no_stall_count got %0d exp 6", bus.Instr_Count); end
    vec++; if (en !== 5'b00010) begin errs++; $display("FAIL jmp_back_fetch got %b exp %b", en, 5'b00010); end
  endtask

  task automatic test_sta_stall;
    bus.Opcode = 4'h1;
    bus.Mem_Ready = 1'b1;
    tick;
    bus.Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++; if ({bus.X_sel, bus.Addr_sel, en} !== 7'b0_1_00001) begin errs++; $display("FAIL sta_stall%0d got %b exp %b", i, {bus.X_sel, bus.Addr_sel, en}, 7'b0_1_00001); end
      vec++; if (bus.Instr_Count !== 8'd6) begin errs++; $display("FAIL sta_stall_count%0d got %0d exp 6", i, bus.Instr_Count); end
      tick;
    end
    bus.Mem_Ready = 1'b1;
    #1;
    vec++; if (en !== 5'b00001) begin errs++; $display("FAIL sta_ready_en got %b exp %b", en, 5'b00001); end
    tick;
    vec++; if (bus.Instr_Count !== 8'd7) begin errs++; $display("FAIL sta_count got %0d exp 7", bus.Instr_Count); end
    vec++; if (en !== 5'b11010) begin errs++; $display("FAIL sta_back_fetch got %b exp %b", en, 5'b11010); end
  endtask

  task automatic test_reset_mid_stall;
    bus.Opcode = 4'h1;
    tick;
    bus.Mem_Ready = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    vec++; if (en !== 5'b00000) begin errs++; $display("FAIL rst_stall_en got %b exp %b", en, 5'b00000); end
    vec++; if (bus.Instr_Count !== 8'd0) begin errs++; $display("FAIL rst_stall_count got %0d exp 0", bus.Instr_Count); end
    tick;
    Reset = 1'b0;
    #1;
    vec++; if (en !== 5'b00010) begin errs++; $display("FAIL rst_stall_refetch got %b exp %b", en, 5'b00010); end
    tick;
    vec++; if (en !== 5'b00010) begin errs++; $display("FAIL rst_stall_hold got %b exp %b", en, 5'b00010); end
  endtask

  task automatic test_halt;
    bus.Opcode = 4'h7;
    bus.Mem_Ready = 1'b1;
    tick;
    vec++; if ({bus.Halted, en} !== 6'b0_00000) begin errs++; $display("FAIL stp_exec got %b exp %b", {bus.Halted, en}, 6'b0_00000); end
    tick;
    vec++; if (bus.Halted !== 1'b1) begin errs++; $display("FAIL halted got %b exp 1", bus.Halted); end
    vec++; if (bus.Instr_Count !== 8'd1) begin errs++; $display("FAIL stp_count got %0d exp 1", bus.Instr_Count); end
    for (int i = 0; i < 10; i++) begin
      bus.Mem_Ready = i[0];
      bus.Opcode = 4'h0;
      #1;
      vec++; if ({bus.Halted, en, bus.Instr_Count} !== {1'b1, 5'b00000, 8'd1}) begin errs++; $display("FAIL halt_hold%0d got %b exp %b", i, {bus.Halted, en, bus.Instr_Count}, {1'b1, 5'b00000, 8'd1}); end
      tick;
    end
    Reset = 1'b1;
    #1;
    vec++; if ({bus.Halted, bus.Instr_Count} !== {1'b0, 8'd0}) begin errs++; $display("FAIL halt_reset got %b exp %b", {bus.Halted, bus.Instr_Count}, {1'b0, 8'd0}); end
    tick;
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_wrap;
    logic [CW-1:0] full;
    full = '1;
    bus.Opcode = 4'h8;
    bus.Mem_Ready = 1'b1;
    tick;
    vec++; if (en !== 5'b00000) begin errs++; $display("FAIL nop_exec_en got %b exp %b", en, 5'b00000); end
    tick;
    vec++; if (bus.Instr_Count !== 8'd1) begin errs++; $display("FAIL nop_count got %0d exp 1", bus.Instr_Count); end
    for (int unsigned k = 0; k < (2**CW) - 2; k++) begin
      tick;
      tick;
    end
    vec++; if (bus.Instr_Count !== full) begin errs++; $display("FAIL count_full got %0h exp %0h", bus.Instr_Count, full); end
    tick;
    tick;
    vec++; if (bus.Instr_Count !== 8'd0) begin errs++; $display("FAIL count_wrap got %0h exp 0", bus.Instr_Count); end
  endtask

  initial begin
    test_reset;
    test_alu_ops;
    test_jumps;
    test_sta_stall;
    test_reset_mid_stall;
    test_halt;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
